// File: rtl/concat_pkg.sv
// Shared types and sizing helpers for the concat read scheduler.
// Watchdog logic elsewhere is built only with CONCAT_SCHED_ERR_EN.
package concat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } frame_flags_t;

    // Counter width for a 0..n-1 range (CHANNEL_NUM, STRING_LEN, FRAME_LINES); never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Idle cycles after a burst so the concatenator can drain the other N-1 channels.
    function automatic int unsigned gap_len(input int unsigned n, input int unsigned c);
        return (n - 1) * c;
    endfunction

endpackage

// File: rtl/concat_sched_if.sv
// Output bus from the scheduler to concat_channels: one word per source plus framing.
interface concat_sched_if #(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic signed [DATA_WIDTH-1:0] data_o [N];
    logic                         data_valid_o;
    logic                         sop_o;
    logic                         eop_o;
    logic                         sof_o;
    logic                         eof_o;

    modport master (output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o);
    modport slave  (input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o);
endinterface

// File: rtl/concat_sched_frame_cnt.sv
// Pixel/line counters and sop/eop/sof/eof decode for the word currently being read.
module frame_cnt
    import concat_pkg::*;
#(
    parameter int unsigned STRING_LEN  = 224,
    parameter int unsigned FRAME_LINES = 224
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         first_word_i,
    input  logic         pix_done_i,
    output frame_flags_t flags_c
);
    localparam int unsigned PIX_W  = cnt_w(STRING_LEN);
    localparam int unsigned LINE_W = cnt_w(FRAME_LINES);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(STRING_LEN - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              sop_c, eop_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (pix_done_i) begin
            if (pix_q == PIX_LAST) begin
                pix_d  = '0;
                line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
            end else begin
                pix_d = pix_q + PIX_W'(1);
            end
        end
    end

    assign sop_c = first_word_i && (pix_q == '0);
    assign eop_c = pix_done_i && (pix_q == PIX_LAST);

    always_comb begin
        flags_c     = '0;
        flags_c.sop = sop_c;
        flags_c.eop = eop_c;
        flags_c.sof = sop_c && (line_q == '0);
        flags_c.eof = eop_c && (line_q == LINE_LAST);
    end
endmodule

// File: rtl/concat_sched.sv
// Read scheduler for concat_channels: bursts CHANNEL_NUM words from all sources per pixel.
// Define CONCAT_SCHED_ERR_EN to add the partial-ready stall watchdog (stall_err_o).
module concat_sched
    import concat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned NUMBER_CONCAT_CHANNELS = 2,
    parameter int unsigned CHANNEL_NUM            = 8,
    parameter int unsigned STRING_LEN             = 224,
    parameter int unsigned FRAME_LINES            = 224
`ifdef CONCAT_SCHED_ERR_EN
    , parameter int unsigned TIMEOUT_CYCLES       = 4096
`endif
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 en_i,
    input  logic [NUMBER_CONCAT_CHANNELS-1:0]    src_ready_i,
    input  logic signed [DATA_WIDTH-1:0]         src_data_i [0:NUMBER_CONCAT_CHANNELS-1],
    output logic [NUMBER_CONCAT_CHANNELS-1:0]    src_rd_o,
    concat_sched_if.master                       out_if,
    output logic                                 busy_o
`ifdef CONCAT_SCHED_ERR_EN
    , output logic                               stall_err_o
`endif
);
    localparam int unsigned N     = NUMBER_CONCAT_CHANNELS;
    localparam int unsigned C     = CHANNEL_NUM;
    localparam int unsigned G     = gap_len(N, C);
    localparam int unsigned CNT_W = cnt_w((G > C) ? G : C);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'((G > 0) ? G - 1 : 0);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         go_c, first_word_c, burst_last_c;
    frame_flags_t                 flags_c;

    logic                         rd_q, rd_d, rd_dly_q, rd_dly_d, valid_q, valid_d, busy_q, busy_d;
    frame_flags_t                 flg1_q, flg1_d, flg_q, flg_d;
    logic signed [DATA_WIDTH-1:0] data_q [N];
    logic signed [DATA_WIDTH-1:0] data_d [N];

    // Ready is only looked at here, so a drop mid-pixel never truncates a burst.
    assign go_c         = en_i && (&src_ready_i);
    assign first_word_c = (state_q == BURST) && (cnt_q == '0);
    assign burst_last_c = (state_q == BURST) && (cnt_q == C_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go_c) state_d = BURST;
            end
            BURST: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (N > 1) state_d = GAP;
                    else       state_d = go_c ? BURST : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == G_LAST) begin
                    cnt_d   = '0;
                    state_d = go_c ? BURST : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Two-stage pipe: rd -> source q valid -> registered output; framing rides alongside.
    always_comb begin
        rd_d     = (state_d == BURST);
        busy_d   = (state_d != IDLE);
        rd_dly_d = rd_q;
        valid_d  = rd_dly_q;
        flg1_d   = flags_c;
        flg_d    = flg1_q;
        data_d   = data_q;
        if (rd_dly_q) data_d = src_data_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            flg1_q   <= '0;
            flg_q    <= '0;
            data_q   <= '{default: '0};
        end else begin
            rd_q     <= rd_d;
            rd_dly_q <= rd_dly_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            flg1_q   <= flg1_d;
            flg_q    <= flg_d;
            data_q   <= data_d;
        end
    end

    frame_cnt #(
        .STRING_LEN  (STRING_LEN),
        .FRAME_LINES (FRAME_LINES)
    ) u_frame_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .first_word_i (first_word_c),
        .pix_done_i   (burst_last_c),
        .flags_c      (flags_c)
    );

    assign src_rd_o            = {N{rd_q}};
    assign busy_o              = busy_q;
    assign out_if.data_o       = data_q;
    assign out_if.data_valid_o = valid_q;
    assign out_if.sop_o        = flg_q.sop;
    assign out_if.eop_o        = flg_q.eop;
    assign out_if.sof_o        = flg_q.sof;
    assign out_if.eof_o        = flg_q.eof;

`ifdef CONCAT_SCHED_ERR_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d, partial_c;

    // Some sources ready and others not while idle: a source is likely stuck.
    assign partial_c = (state_q == IDLE) && (|src_ready_i) && !(&src_ready_i);

    always_comb begin
        wd_d  = '0;
        err_d = err_q;
        if (partial_c) wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1);
        if (wd_d == WD_LIMIT) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign stall_err_o = err_q;
`endif
endmodule

// File: tb/tb_concat_sched.sv
// Scoreboard bench for concat_sched (N=2, C=8, 4x2 frame); source FIFOs modelled with 1-cycle q latency.
module tb_concat_sched;
    localparam int unsigned N  = 2;
    localparam int unsigned C  = 8;
    localparam int unsigned SL = 4;
    localparam int unsigned FL = 2;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [3:0]      flg;
        logic [31:0]     cyc;
    } exp_t;

    logic                 clk     = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 en_i    = 1'b0;
    logic [N-1:0]         src_ready_i = '0;
    logic signed [DW-1:0] src_data_i [0:N-1];
    logic [N-1:0]         src_rd_o;
    logic                 busy_o;
`ifdef CONCAT_SCHED_ERR_EN
    logic                 stall_err_o;
`endif

    concat_sched_if #(.N(N), .DATA_WIDTH(DW)) out_if ();

    concat_sched #(
        .DATA_WIDTH             (DW),
        .NUMBER_CONCAT_CHANNELS (N),
        .CHANNEL_NUM            (C),
        .STRING_LEN             (SL),
        .FRAME_LINES            (FL)
`ifdef CONCAT_SCHED_ERR_EN
        , .TIMEOUT_CYCLES       (16)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (en_i),
        .src_ready_i (src_ready_i),
        .src_data_i  (src_data_i),
        .src_rd_o    (src_rd_o),
        .out_if      (out_if),
        .busy_o      (busy_o)
`ifdef CONCAT_SCHED_ERR_EN
        , .stall_err_o (stall_err_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int n_words = 0, n_sop = 0, n_eop = 0, n_sof = 0, n_eof = 0;

    exp_t            sb_q[$];
    exp_t            e_push, e_pop;
    logic            pend = 1'b0;
    int              widx = 0, pix = 0, line = 0;
    logic [2*DW-1:0] last_data = '0;
    logic [3:0]      obs_f;
    logic [2*DW-1:0] obs_d;
    logic [2*DW-1:0] v;

    // Source FIFO model + output scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        ncyc++;
        obs_f = {out_if.sop_o, out_if.eop_o, out_if.sof_o, out_if.eof_o};
        obs_d = {out_if.data_o[1], out_if.data_o[0]};
        if (!reset_n) begin
            sb_q.delete();
            pend = 1'b0;
            widx = 0; pix = 0; line = 0;
            last_data = '0;
        end else begin
            checks++;
            if (out_if.data_valid_o) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: cycle %0d data_valid_o=1 data=%h, expected no word", ncyc, obs_d);
                end else begin
                    e_pop = sb_q.pop_front();
                    if (obs_d !== e_pop.data || obs_f !== e_pop.flg || e_pop.cyc != 32'(ncyc - 1)) begin
                        errors++;
                        $display("FAIL sb_word: cycle %0d got data=%h flags=%b, want data=%h flags=%b (queued cycle %0d)",
                                 ncyc, obs_d, obs_f, e_pop.data, e_pop.flg, e_pop.cyc);
                    end
                    last_data = e_pop.data;
                    n_words++;
                    n_sop += int'(obs_f[3]); n_eop += int'(obs_f[2]);
                    n_sof += int'(obs_f[1]); n_eof += int'(obs_f[0]);
                end
            end else begin
                if (sb_q.size() != 0 || obs_f !== 4'b0 || obs_d !== last_data) begin
                    errors++;
                    $display("FAIL idle_out: cycle %0d valid=0 pending=%0d flags=%b data=%h, want pending=0 flags=0000 data=%h",
                             ncyc, sb_q.size(), obs_f, obs_d, last_data);
                    sb_q.delete();
                end
            end

            if (pend) begin
                v = 16'($urandom);
                src_data_i[0] = v[7:0];
                src_data_i[1] = v[15:8];
                e_push.data = v;
                e_push.flg  = {(widx == 0 && pix == 0), (widx == C-1 && pix == SL-1),
                               (widx == 0 && pix == 0 && line == 0),
                               (widx == C-1 && pix == SL-1 && line == FL-1)};
                e_push.cyc  = 32'(ncyc);
                sb_q.push_back(e_push);
                if (widx == C-1) begin
                    widx = 0;
                    if (pix == SL-1) begin
                        pix  = 0;
                        line = (line == FL-1) ? 0 : line + 1;
                    end else begin
                        pix = pix + 1;
                    end
                end else begin
                    widx = widx + 1;
                end
            end else begin
                src_data_i[0] = 8'($urandom);
                src_data_i[1] = 8'($urandom);
            end

            checks++;
            if (src_rd_o[0] !== src_rd_o[1]) begin
                errors++;
                $display("FAIL rd_equal: cycle %0d src_rd_o=%b, want both bits equal", ncyc, src_rd_o);
            end
            pend = src_rd_o[0];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd_rise();
        int n = 0;
        while (src_rd_o[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (src_rd_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rd_timeout: src_rd_o=%b after %0d cycles, want burst start", src_rd_o, n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        en_i = 1'b0;
        while (busy_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (busy_o !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle: busy_o=%b pending=%0d, want 0 and 0", busy_o, sb_q.size());
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (src_rd_o !== '0 || busy_o !== 1'b0 || out_if.data_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rd=%b busy=%b valid=%b, want 0", src_rd_o, busy_o, out_if.data_valid_o);
        end
        checks++;
        if ({out_if.sop_o, out_if.eop_o, out_if.sof_o, out_if.eof_o} !== 4'b0 ||
            {out_if.data_o[1], out_if.data_o[0]} !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: flags=%b data=%h, want 0",
                     {out_if.sop_o, out_if.eop_o, out_if.sof_o, out_if.eof_o}, {out_if.data_o[1], out_if.data_o[0]});
        end
`ifdef CONCAT_SCHED_ERR_EN
        checks++;
        if (stall_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: stall_err_o=%b, want 0", stall_err_o);
        end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_framing();
        int bursts = 0, n = 0;
        logic prev = 1'b0;
        n_words = 0; n_sop = 0; n_eop = 0; n_sof = 0; n_eof = 0;
        src_ready_i = '1;
        en_i = 1'b1;
        while (bursts < 8 && n < 300) begin
            tick();
            n++;
            if (src_rd_o[0] && !prev) bursts++;
            prev = src_rd_o[0];
        end
        wait_idle();
        checks++;
        if (n_words != 64 || n_sop != 2 || n_eop != 2 || n_sof != 1 || n_eof != 1) begin
            errors++;
            $display("FAIL framing_8px: words=%0d sop=%0d eop=%0d sof=%0d eof=%0d, want 64 2 2 1 1",
                     n_words, n_sop, n_eop, n_sof, n_eof);
        end
        // Ninth pixel: both counters have wrapped back to pixel 0, line 0.
        en_i = 1'b1;
        wait_rd_rise();
        en_i = 1'b0;
        wait_idle();
        checks++;
        if (n_sof != 2 || n_sop != 3 || n_eof != 1 || n_words != 72) begin
            errors++;
            $display("FAIL framing_wrap: sof=%0d sop=%0d eof=%0d words=%0d, want 2 3 1 72", n_sof, n_sop, n_eof, n_words);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        src_ready_i = '1;
        en_i = 1'b1;
        wait_rd_rise();
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (src_rd_o[0] !== ((i % 16) < 8)) begin
                errors++;
                $display("FAIL rd_period: offset %0d src_rd_o=%b, want %0b", i, src_rd_o[0], ((i % 16) < 8));
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_b2b: offset %0d busy_o=%b, want 1", i, busy_o);
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_partial_ready();
        src_ready_i = 2'b01;
        en_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (src_rd_o !== '0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL partial_ready: cycle %0d rd=%b busy=%b, want 0 0", i, src_rd_o, busy_o);
            end
        end
        src_ready_i = 2'b11;
        #1;
        checks++;
        if (src_rd_o !== '0) begin
            errors++;
            $display("FAIL ready_same_cycle: rd=%b, want 00", src_rd_o);
        end
        tick();
        checks++;
        if (src_rd_o !== 2'b11 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_next_cycle: rd=%b busy=%b, want 11 1", src_rd_o, busy_o);
        end
        wait_idle();
    endtask

    task automatic test_en_drop();
        int off = 0, nrd = 1, stray = 0;
        src_ready_i = '1;
        en_i = 1'b1;
        wait_rd_rise();
        while (busy_o === 1'b1 && off < 40) begin
            tick();
            off++;
            if (off == 3) begin
                en_i = 1'b0;
                src_ready_i = '0;
            end
            if (src_rd_o[0]) nrd++;
        end
        checks++;
        if (nrd != 8) begin
            errors++;
            $display("FAIL en_drop_words: rd cycles=%0d, want 8", nrd);
        end
        checks++;
        if (off != 16) begin
            errors++;
            $display("FAIL en_drop_busy: busy fell at offset %0d, want 16", off);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (src_rd_o !== '0 || busy_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL en_drop_idle: %0d cycles with rd/busy after stop, want 0", stray);
        end
        checks++;
        if ({out_if.data_o[1], out_if.data_o[0]} !== last_data) begin
            errors++;
            $display("FAIL data_hold: data=%h, want %h", {out_if.data_o[1], out_if.data_o[0]}, last_data);
        end
    endtask

    task automatic test_reset_mid();
        int sof0;
        src_ready_i = '1;
        en_i = 1'b1;
        wait_rd_rise();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (src_rd_o !== '0 || busy_o !== 1'b0 || out_if.data_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: rd=%b busy=%b valid=%b, want 0", src_rd_o, busy_o, out_if.data_valid_o);
        end
        checks++;
        if ({out_if.sop_o, out_if.eop_o, out_if.sof_o, out_if.eof_o} !== 4'b0 ||
            {out_if.data_o[1], out_if.data_o[0]} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_data: flags=%b data=%h, want 0",
                     {out_if.sop_o, out_if.eop_o, out_if.sof_o, out_if.eof_o}, {out_if.data_o[1], out_if.data_o[0]});
        end
        tick();
        tick();
        sof0 = n_sof;
        reset_n = 1'b1;
        wait_rd_rise();
        en_i = 1'b0;
        wait_idle();
        checks++;
        if (n_sof != sof0 + 1) begin
            errors++;
            $display("FAIL reset_restart_sof: sof count %0d, want %0d", n_sof, sof0 + 1);
        end
    endtask

`ifdef CONCAT_SCHED_ERR_EN
    task automatic test_stall();
        src_ready_i = 2'b10;
        en_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (stall_err_o !== (k == 16)) begin
                errors++;
                $display("FAIL stall_rise: after %0d cycles stall_err_o=%b, want %0b", k, stall_err_o, (k == 16));
            end
        end
        src_ready_i = 2'b11;
        repeat (40) tick();
        wait_idle();
        checks++;
        if (stall_err_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_sticky: stall_err_o=%b, want 1", stall_err_o);
        end
    endtask
`endif

    initial begin
        src_data_i[0] = '0;
        src_data_i[1] = '0;
        test_reset();
        test_framing();
        test_back_to_back();
        test_partial_ready();
        test_en_drop();
        test_reset_mid();
`ifdef CONCAT_SCHED_ERR_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
